block_scheduler: RTL

Parametrised kernel block scheduler: splits a launch of thread_count threads into blocks of THREADS_PER_BLOCK and hands them to NUM_CORES compute cores.
- One block dispatch per cycle; the next core is picked round-robin among enabled free cores.
- Supports a per-launch core enable mask, abort, multiple completions in the same cycle, and error reporting.
- Sits between the GPU control registers and the core array.

---
 rtl/sched_pkg.sv | 25 ++
 rtl/rr_picker.sv | 32 +++
 rtl/block_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sched_pkg.sv
// Shared types and helpers for the kernel block scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ABORT,
    S_DONE
  } sched_state_t;

  typedef enum logic {
    SLOT_FREE,
    SLOT_BUSY
  } slot_state_t;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int tpb_width(input int tpb);
    return $clog2(tpb + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-one finder: grants the first set request at or after ptr.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  function automatic logic [PTR_W-1:0] rot(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[rot(ptr, i)]) begin
        valid = 1'b1;
        idx   = rot(ptr, i);
      end
    end
    grant = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/block_scheduler.sv
// Splits a launch into fixed-size thread blocks and dispatches them round-robin
// to enabled free cores, one block per cycle.
module block_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_CORES         = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_CNT_W      = 8,
  parameter int BLOCK_ID_W        = 4,
  parameter int TPB_W             = tpb_width(THREADS_PER_BLOCK)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [THREAD_CNT_W-1:0]          thread_count,
  input  logic [NUM_CORES-1:0]             core_enable_mask,
  input  logic                             abort,
  input  logic [NUM_CORES-1:0]             core_done,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES-1:0]             core_reset,
  output logic [NUM_CORES*BLOCK_ID_W-1:0]  core_block_id,
  output logic [NUM_CORES*TPB_W-1:0]       core_thread_count,
  output logic [THREAD_CNT_W-1:0]          blocks_done_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int TOT_W = THREAD_CNT_W + 1;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t            state, state_next;
  slot_state_t             slot    [NUM_CORES];
  logic [BLOCK_ID_W-1:0]   blk_id  [NUM_CORES];
  logic [TPB_W-1:0]        blk_cnt [NUM_CORES];

  logic [THREAD_CNT_W-1:0] tc_lat;
  logic [NUM_CORES-1:0]    mask_lat;
  logic [TOT_W-1:0]        total, total_calc, dispatched;
  logic [PTR_W-1:0]        ptr, pick_idx;
  logic [NUM_CORES-1:0]    busy_mask, done_hits, pick_grant;
  logic                    pick_valid, launch_err, do_dispatch;
  logic [TPB_W-1:0]        next_count;
  int unsigned             rem;

  always_comb begin
    busy_mask         = '0;
    core_block_id     = '0;
    core_thread_count = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      busy_mask[i] = (slot[i] == SLOT_BUSY);
      core_block_id[i*BLOCK_ID_W +: BLOCK_ID_W] = blk_id[i];
      core_thread_count[i*TPB_W +: TPB_W]       = blk_cnt[i];
    end
  end

  assign core_start = busy_mask;
  assign core_reset = ~busy_mask;
  assign done_hits  = core_done & busy_mask;
  assign busy       = (state == S_LAUNCH) || (state == S_RUN) || (state == S_ABORT);
  assign done       = (state == S_DONE);

  // Launch sizing uses the live inputs; the same values are latched on this edge.
  assign total_calc = TOT_W'(ceil_div(32'(thread_count), 32'(THREADS_PER_BLOCK)));
  assign launch_err = ((total_calc != '0) && (core_enable_mask == '0)) ||
                      (32'(total_calc) > (32'd1 << BLOCK_ID_W));

  // Only slots free before this edge are candidates, so a freed core sees a full reset cycle.
  rr_picker #(.N(NUM_CORES), .PTR_W(PTR_W)) u_picker (
    .req   (mask_lat & ~busy_mask),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign do_dispatch = (state == S_RUN) && !abort && (dispatched < total) && pick_valid;

  always_comb begin
    rem        = 32'(tc_lat) - 32'(dispatched) * 32'(THREADS_PER_BLOCK);
    next_count = (rem >= 32'(THREADS_PER_BLOCK)) ? TPB_W'(THREADS_PER_BLOCK) : TPB_W'(rem);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_LAUNCH;
      S_LAUNCH: begin
        if (abort)                                    state_next = S_ABORT;
        else if (launch_err || (total_calc == '0))   state_next = S_DONE;
        else                                          state_next = S_RUN;
      end
      S_RUN: begin
        if (abort)                                    state_next = S_ABORT;
        else if (TOT_W'(blocks_done_count) == total) state_next = S_DONE;
      end
      S_ABORT:  state_next = S_IDLE;
      S_DONE:   if (!start) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      tc_lat            <= '0;
      mask_lat          <= '0;
      total             <= '0;
      dispatched        <= '0;
      ptr               <= '0;
      blocks_done_count <= '0;
      error             <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        slot[i]    <= SLOT_FREE;
        blk_id[i]  <= '0;
        blk_cnt[i] <= '0;
      end
    end else begin
      state <= state_next;
      if (state_next == S_IDLE) error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          dispatched        <= '0;
          ptr               <= '0;
          blocks_done_count <= '0;
        end
        S_LAUNCH: begin
          tc_lat   <= thread_count;
          mask_lat <= core_enable_mask;
          total    <= total_calc;
          error    <= !abort && launch_err;
        end
        S_RUN: begin
          if (abort) begin
            for (int i = 0; i < NUM_CORES; i++) slot[i] <= SLOT_FREE;
          end else begin
            blocks_done_count <= blocks_done_count + THREAD_CNT_W'($countones(done_hits));
            for (int i = 0; i < NUM_CORES; i++) begin
              if (done_hits[i]) slot[i] <= SLOT_FREE;
              if (do_dispatch && pick_grant[i]) begin
                slot[i]    <= SLOT_BUSY;
                blk_id[i]  <= BLOCK_ID_W'(dispatched);
                blk_cnt[i] <= next_count;
              end
            end
            if (do_dispatch) begin
              dispatched <= dispatched + 1'b1;
              ptr        <= (int'(pick_idx) == NUM_CORES - 1) ? '0 : pick_idx + 1'b1;
            end
          end
        end
        default: begin
          for (int i = 0; i < NUM_CORES; i++) slot[i] <= SLOT_FREE;
        end
      endcase
    end
  end

endmodule
